// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM: controller state
// encoding and the read-during-write mode selectors.
package ram_pkg;

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_byte_lane.sv
// One 8-bit slice of the RAM. The read address is captured on an accepted
// read and the array is looked up through the captured address, so a write to
// that address on the same edge is already visible on rd_data. wr_old exposes
// the word currently stored at the write address so the top level can
// preserve pre-write contents on a collision.
module ram_byte_lane #(
   parameter int AWIDTH = 3
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [7:0]        wr_old
);

   localparam int DEPTH = 2 ** AWIDTH;

   logic [7:0]        mem [DEPTH];
   logic [AWIDTH-1:0] rd_addr_q;

   // Array write and read-address capture; the array is cleared only by the sweep, never by reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_addr_q <= rd_addr;
      end
   end

   assign rd_data = mem[rd_addr_q];
   assign wr_old  = mem[wr_addr];

endmodule

// File: rtl/ram_sync_dp_be.sv
// Synchronous dual-port RAM with byte enables, a zero-fill sweep after reset
// or on request, selectable read-during-write behaviour and an optional
// output register. Reads and writes are ignored while the sweep runs.
module ram_sync_dp_be
   import ram_pkg::*;
#(
   parameter int AWIDTH   = 3,
   parameter int DWIDTH   = 32,
   parameter int RDW_MODE = 0,
   parameter int OUT_REG  = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_req,
   output logic                init_done,
   input  logic                wr_en,
   input  logic [AWIDTH-1:0]   wr_addr,
   input  logic [DWIDTH/8-1:0] wr_be,
   input  logic [DWIDTH-1:0]   wr_data,
   input  logic                rd_en,
   input  logic [AWIDTH-1:0]   rd_addr,
   output logic [DWIDTH-1:0]   rd_data,
   output logic                rd_valid
);

   localparam int DEPTH  = 2 ** AWIDTH;
   localparam int NBYTES = DWIDTH / 8;
   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

   logic [0:0]        state;
   logic [AWIDTH-1:0] clr_addr;
   logic              clearing;
   logic              rd_accept;
   logic              wr_active;
   logic              collision;
   logic [AWIDTH-1:0] lane_wr_addr;
   logic [DWIDTH-1:0] lane_wr_data;
   logic [NBYTES-1:0] lane_we;
   logic [DWIDTH-1:0] lane_rd_word;
   logic [DWIDTH-1:0] lane_old_word;

   logic              s1_valid;
   logic              s1_coll;
   logic [DWIDTH-1:0] s1_old;
   logic [DWIDTH-1:0] word_sel;
   logic              p_valid;
   logic [DWIDTH-1:0] p_data;

   assign clearing  = (state == CLEAR);
   assign init_done = ~clearing;
   assign rd_accept = rd_en & ~clearing;
   assign wr_active = wr_en & ~clearing;

   // Old-data mode only needs the bypass when a real byte is written to the word being read
   assign collision = (RDW_MODE == RDW_OLD) && rd_accept && wr_active &&
                      (wr_addr == rd_addr) && (|wr_be);

   assign lane_wr_addr = clearing ? clr_addr : wr_addr;
   assign lane_wr_data = clearing ? '0 : wr_data;

   // Per-lane write strobes: the sweep writes every byte, normal writes honour the byte enables
   always_comb begin
      for (int i = 0; i < NBYTES; i++) begin
         lane_we[i] = clearing | (wr_active & wr_be[i]);
      end
   end

   for (genvar g = 0; g < NBYTES; g++) begin : g_lane
      ram_byte_lane #(
         .AWIDTH (AWIDTH)
      ) u_lane (
         .clock   (clock),
         .wr_en   (lane_we[g]),
         .wr_addr (lane_wr_addr),
         .wr_data (lane_wr_data[8*g +: 8]),
         .rd_en   (rd_accept),
         .rd_addr (rd_addr),
         .rd_data (lane_rd_word[8*g +: 8]),
         .wr_old  (lane_old_word[8*g +: 8])
      );
   end

   // Controller: zero-fill sweep from address 0 to DEPTH-1, then serve traffic until a clear request
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else if (state == CLEAR) begin
         clr_addr <= clr_addr + 1'b1;
         if (clr_addr == LAST_ADDR) begin
            state <= READY;
         end
      end else if (clear_req) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end
   end

   // First read stage flags: an accepted read and whether it collided with a write in old-data mode
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_coll  <= 1'b0;
      end else begin
         s1_valid <= rd_accept;
         s1_coll  <= collision;
      end
   end

   // Pre-write word kept aside on a collision so old-data mode can return it
   always_ff @(posedge clock) begin
      if (collision) begin
         s1_old <= lane_old_word;
      end
   end

   assign word_sel = s1_coll ? s1_old : lane_rd_word;

   // Read result register: updates only on a completed read, otherwise holds the last word
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p_valid <= 1'b0;
         p_data  <= '0;
      end else begin
         p_valid <= s1_valid;
         if (s1_valid) begin
            p_data <= word_sel;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic              o_valid;
      logic [DWIDTH-1:0] o_data;

      // Optional extra output stage, same hold-last-value behaviour as the result register
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
         end else begin
            o_valid <= p_valid;
            if (p_valid) begin
               o_data <= p_data;
            end
         end
      end

      assign rd_valid = o_valid;
      assign rd_data  = o_data;
   end else begin : g_no_out_reg
      assign rd_valid = p_valid;
      assign rd_data  = p_data;
   end

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Directed bench for ram_sync_dp_be. Two instances share all inputs:
// dut0 returns old data with no output register, dut1 returns new data with
// the output register, so every read is checked at both latencies.
module tb_ram_sync_dp_be;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear_req;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [2:0]  rd_addr;

   logic        init_done0, init_done1;
   logic [31:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(0), .OUT_REG(0)) dut0 (
      .clock(clock), .reset(reset), .clear_req(clear_req), .init_done(init_done0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
   );

   ram_sync_dp_be #(.AWIDTH(3), .DWIDTH(32), .RDW_MODE(1), .OUT_REG(1)) dut1 (
      .clock(clock), .reset(reset), .clear_req(clear_req), .init_done(init_done1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
   );

   // Advance one clock and settle just past the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
      tick();
      wr_en = 1'b0;
   endtask

   // Issue one read (any write already set up rides the same edge) and check both instances
   task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp0, input logic [31:0] exp1);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      tick();
      check_output({tag, "_v0"}, 32'(rd_valid0), 32'd1);
      check_output({tag, "_d0"}, rd_data0, exp0);
      check_output({tag, "_v1_early"}, 32'(rd_valid1), 32'd0);
      tick();
      check_output({tag, "_v1"}, 32'(rd_valid1), 32'd1);
      check_output({tag, "_d1"}, rd_data1, exp1);
      check_output({tag, "_v0_once"}, 32'(rd_valid0), 32'd0);
   endtask

   // Count cycles until init_done rises, bounded, noting any stray rd_valid
   task automatic wait_init(output int cnt, output logic seen_valid);
      cnt        = 0;
      seen_valid = 1'b0;
      while (!init_done0 && cnt < 20) begin
         tick();
         cnt++;
         if (rd_valid0 || rd_valid1) seen_valid = 1'b1;
      end
   endtask

   initial begin
      int   cnt;
      logic seen;

      reset     = 1'b1;
      clear_req = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_be     = '0;
      wr_data   = '0;
      rd_en     = 1'b0;
      rd_addr   = '0;

      tick();
      check_output("rst_init_done0", 32'(init_done0), 32'd0);
      check_output("rst_init_done1", 32'(init_done1), 32'd0);
      check_output("rst_rd_valid0", 32'(rd_valid0), 32'd0);
      check_output("rst_rd_valid1", 32'(rd_valid1), 32'd0);
      check_output("rst_rd_data0", rd_data0, 32'h0);
      check_output("rst_rd_data1", rd_data1, 32'h0);
      tick();
      reset = 1'b0;

      wait_init(cnt, seen);
      check_output("init_sweep_cycles", 32'(cnt), 32'd8);
      check_output("init_done1_rise", 32'(init_done1), 32'd1);
      check_output("init_no_rd_valid", 32'(seen), 32'd0);

      read_check("rd_zero_a5", 3'd5, 32'h0, 32'h0);

      apply_stimulus(3'd2, 32'hDEADBEEF, 4'hF);
      apply_stimulus(3'd2, 32'h11223344, 4'b0101);
      read_check("byte_merge_a2", 3'd2, 32'hDE22BE44, 32'hDE22BE44);

      apply_stimulus(3'd2, 32'hFFFFFFFF, 4'h0);
      read_check("be_zero_noop", 3'd2, 32'hDE22BE44, 32'hDE22BE44);

      apply_stimulus(3'd3, 32'hAAAAAAAA, 4'hF);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h55555555; wr_be = 4'hF;
      read_check("rdw_full", 3'd3, 32'hAAAAAAAA, 32'h55555555);

      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h12345678; wr_be = 4'b0011;
      read_check("rdw_partial", 3'd3, 32'h55555555, 32'h55555678);

      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
      read_check("diff_addr_rd", 3'd2, 32'hDE22BE44, 32'hDE22BE44);
      read_check("diff_addr_wr", 3'd4, 32'hCAFEF00D, 32'hCAFEF00D);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(3'(i), 32'hA0000000 | 32'(i), 4'hF);
      end
      for (int t = 1; t <= 11; t++) begin
         if (t <= 8) begin
            rd_en   = 1'b1;
            rd_addr = 3'(t - 1);
         end else begin
            rd_en = 1'b0;
         end
         tick();
         check_output($sformatf("b2b_v0_t%0d", t), 32'(rd_valid0), 32'((t >= 2) && (t <= 9)));
         check_output($sformatf("b2b_v1_t%0d", t), 32'(rd_valid1), 32'((t >= 3) && (t <= 10)));
         if ((t >= 2) && (t <= 9)) check_output($sformatf("b2b_d0_t%0d", t), rd_data0, 32'hA0000000 | 32'(t - 2));
         if ((t >= 3) && (t <= 10)) check_output($sformatf("b2b_d1_t%0d", t), rd_data1, 32'hA0000000 | 32'(t - 3));
      end
      check_output("hold_d0", rd_data0, 32'hA0000007);
      check_output("hold_d1", rd_data1, 32'hA0000007);

      clear_req = 1'b1;
      tick();
      check_output("clr_init_low", 32'(init_done0), 32'd0);
      cnt  = 0;
      seen = 1'b0;
      while (!init_done0 && cnt < 20) begin
         wr_en   = 1'b1;
         wr_addr = 3'(cnt);
         wr_data = 32'hFFFFFFFF;
         wr_be   = 4'hF;
         rd_en   = 1'b1;
         rd_addr = 3'(cnt);
         tick();
         cnt++;
         if (rd_valid0 || rd_valid1) seen = 1'b1;
      end
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      clear_req = 1'b0;
      check_output("clr_sweep_cycles", 32'(cnt), 32'd8);
      check_output("clr_no_rd_valid", 32'(seen), 32'd0);
      for (int i = 0; i < 8; i++) begin
         read_check($sformatf("clr_zero_a%0d", i), 3'(i), 32'h0, 32'h0);
      end

      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      rd_en     = 1'b1;
      rd_addr   = 3'd1;
      for (int i = 0; i < 4; i++) tick();
      #2;
      reset = 1'b1;
      rd_en = 1'b0;
      #1;
      check_output("sweep_rst_init", 32'(init_done0), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (rd_valid0 || rd_valid1) seen = 1'b1;
      end
      reset = 1'b0;
      wait_init(cnt, seen);
      check_output("sweep_rst_cycles", 32'(cnt), 32'd8);
      check_output("sweep_rst_no_valid", 32'(seen), 32'd0);

      apply_stimulus(3'd1, 32'h12345678, 4'hF);
      read_check("pre_rst_a1", 3'd1, 32'h12345678, 32'h12345678);
      rd_en   = 1'b1;
      rd_addr = 3'd1;
      tick();
      rd_en = 1'b0;
      reset = 1'b1;
      #1;
      check_output("midrd_rst_data0", rd_data0, 32'h0);
      check_output("midrd_rst_data1", rd_data1, 32'h0);
      check_output("midrd_rst_init1", 32'(init_done1), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rd_valid0 || rd_valid1) seen = 1'b1;
      end
      check_output("midrd_rst_no_valid", 32'(seen), 32'd0);
      reset = 1'b0;
      wait_init(cnt, seen);
      check_output("midrd_rst_cycles", 32'(cnt), 32'd8);
      check_output("midrd_rst_no_valid2", 32'(seen), 32'd0);
      read_check("post_rst_zero_a1", 3'd1, 32'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
